// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one clock-enabled W-bit register among N requesters.
// Optional write counter output WR_CNT is built when ARB_STATS_EN is defined.
module reg_write_arbiter #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [N-1:0]   REQ,
   input  logic [N*W-1:0] DATA_IN,
   output logic [W-1:0]   Q,
   output logic           EN_OUT,
   output logic [N-1:0]   GNT,
   output logic [N-1:0]   ACK,
   output logic           BUSY
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]    WR_CNT
`endif
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [PW-1:0] ptr_r, ptr_s, win_r, win_s, pick_s;
   logic [N-1:0]  gnt_r, gnt_s, ack_r, ack_s;
   logic          en_r, en_s, busy_r, busy_s;
   logic [W-1:0]  q_r, q_s;

   function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = (idx == PW'(i));
      return v;
   endfunction

   function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
      int s;
      s = (int'(base) + off) % N;
      return PW'(s);
   endfunction

   // Round-robin search: walk offsets from far to near so the nearest requester after ptr wins
   always_comb begin
      pick_s = ptr_r;
      for (int off = N; off >= 1; off--) begin
         if (REQ[rr_index(ptr_r, off)]) pick_s = rr_index(ptr_r, off);
      end
   end

   // Next-state and next-output logic; all outputs come from registers
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      win_s   = win_r;
      gnt_s   = gnt_r;
      ack_s   = '0;
      en_s    = 1'b0;
      busy_s  = busy_r;
      q_s     = q_r;
      case (state_r)
         ST_IDLE: begin
            if (|REQ) begin
               state_s = ST_GRANT;
               win_s   = pick_s;
               gnt_s   = onehot(pick_s);
               en_s    = 1'b1;
               busy_s  = 1'b1;
            end else begin
               gnt_s  = '0;
               busy_s = 1'b0;
            end
         end
         ST_GRANT: begin
            state_s = ST_ACK;
            ack_s   = gnt_r;
            busy_s  = 1'b1;
            for (int i = 0; i < N; i++) begin
               if (win_r == PW'(i)) q_s = DATA_IN[i*W +: W];
            end
         end
         ST_ACK: begin
            state_s = ST_IDLE;
            ptr_s   = win_r;
            gnt_s   = '0;
            busy_s  = 1'b0;
         end
         default: begin
            state_s = ST_IDLE;
            gnt_s   = '0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset leaves requester 0 with first priority
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_IDLE;
         ptr_r   <= PW'(N - 1);
         win_r   <= '0;
         gnt_r   <= '0;
         ack_r   <= '0;
         en_r    <= 1'b0;
         busy_r  <= 1'b0;
         q_r     <= '0;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
         win_r   <= win_s;
         gnt_r   <= gnt_s;
         ack_r   <= ack_s;
         en_r    <= en_s;
         busy_r  <= busy_s;
         q_r     <= q_s;
      end
   end

   assign Q      = q_r;
   assign EN_OUT = en_r;
   assign GNT    = gnt_r;
   assign ACK    = ack_r;
   assign BUSY   = busy_r;

`ifdef ARB_STATS_EN
   logic [15:0] wr_cnt_r;

   // Saturating count of completed writes
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_cnt_r <= 16'h0000;
      end else if (state_r == ST_GRANT && wr_cnt_r != 16'hFFFF) begin
         wr_cnt_r <= wr_cnt_r + 16'h0001;
      end
   end

   assign WR_CNT = wr_cnt_r;
`endif

endmodule
